// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: serial I2S transmitter.
// Takes left/right PCM pairs through a valid/ready handshake into a single
// holding register, generates sck/ws from clk, and shifts each channel out
// MSB-first, starting one bit after the ws transition.
module pcm_to_i2s #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_BITS      = 16,
    parameter int CLK_DIV        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUMBER_OF_BITS-1:0] left_in,
    input  logic [NUMBER_OF_BITS-1:0] right_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      frame_start,
    output logic                      underrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(2 * SLOT_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(2 * SLOT_BITS - 1);
    localparam logic [PW-1:0] WS_LO    = PW'(SLOT_BITS - 1);
    localparam logic [PW-1:0] WS_HI    = PW'(2 * SLOT_BITS - 2);
    localparam logic [PW-1:0] L_LO     = PW'(1);
    localparam logic [PW-1:0] L_HI     = PW'(NUMBER_OF_BITS);
    localparam logic [PW-1:0] R_LO     = PW'(SLOT_BITS + 1);
    localparam logic [PW-1:0] R_HI     = PW'(SLOT_BITS + NUMBER_OF_BITS);

    logic [DW-1:0]             div_cnt_q, div_cnt_d;
    logic                      sck_q, sck_d;
    logic [PW-1:0]             p_q, p_d;
    logic                      ws_q, ws_d;
    logic                      sd_q, sd_d;
    logic                      hold_full_q, hold_full_d;
    logic [NUMBER_OF_BITS-1:0] hold_l_q, hold_l_d;
    logic [NUMBER_OF_BITS-1:0] hold_r_q, hold_r_d;
    logic [NUMBER_OF_BITS-1:0] shl_q, shl_d;
    logic [NUMBER_OF_BITS-1:0] shr_q, shr_d;
    logic                      in_ready_q, in_ready_d;
    logic                      frame_start_q, frame_start_d;
    logic                      underrun_q, underrun_d;

    logic          tick;
    logic          tx;
    logic          load;
    logic          accept;
    logic [PW-1:0] p_next;

    assign tick   = (div_cnt_q == DIV_LAST);
    assign tx     = tick && sck_q;
    assign p_next = (p_q == P_LAST) ? '0 : p_q + PW'(1);
    assign load   = tx && (p_q == P_LAST);
    assign accept = in_valid && in_ready_q;

    // Next-state: divider, bit position, serial outputs on the falling sck edge, holding register
    always_comb begin
        div_cnt_d     = tick ? '0 : div_cnt_q + DW'(1);
        sck_d         = tick ? ~sck_q : sck_q;
        p_d           = p_q;
        ws_d          = ws_q;
        sd_d          = sd_q;
        shl_d         = shl_q;
        shr_d         = shr_q;
        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        frame_start_d = load;
        underrun_d    = load && !hold_full_q;

        if (tx) begin
            p_d  = p_next;
            ws_d = (p_next >= WS_LO) && (p_next <= WS_HI);
            sd_d = 1'b0;
            if (load) begin
                shl_d = hold_full_q ? hold_l_q : '0;
                shr_d = hold_full_q ? hold_r_q : '0;
            end else if ((p_next >= L_LO) && (p_next <= L_HI)) begin
                sd_d  = shl_q[NUMBER_OF_BITS-1];
                shl_d = shl_q << 1;
            end else if ((p_next >= R_LO) && (p_next <= R_HI)) begin
                sd_d  = shr_q[NUMBER_OF_BITS-1];
                shr_d = shr_q << 1;
            end
        end

        if (load && hold_full_q) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = left_in;
            hold_r_d    = right_in;
        end

        // When a load drains the holding register, ready reopens one cycle after frame_start
        in_ready_d = !hold_full_d && !(load && hold_full_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            sck_q         <= 1'b0;
            p_q           <= P_LAST;
            ws_q          <= 1'b0;
            sd_q          <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            shl_q         <= '0;
            shr_q         <= '0;
            in_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            sck_q         <= sck_d;
            p_q           <= p_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            shl_q         <= shl_d;
            shr_q         <= shr_d;
            in_ready_q    <= in_ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign sck         = sck_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb_pcm_to_i2s: directed bench for the I2S transmitter (N=8, SLOT=16, DIV=2).
// A monitor captures each complete frame (sd and ws sampled at every rising
// sck, bit index = slot position p) and the main thread compares frames
// against hand-computed bit patterns.
module tb_pcm_to_i2s;

    localparam int N        = 8;
    localparam int SLOT     = 16;
    localparam int DIV      = 2;
    localparam int FRAME    = 2 * SLOT * 2 * DIV;
    localparam logic [31:0] WS_PATTERN = 32'h7FFF_8000;

    typedef struct {
        logic [7:0]  l;
        logic [7:0]  r;
        logic [31:0] expSd;
        logic        expUr;
    } vec_t;

    typedef struct {
        bit [31:0] sdBits;
        bit [31:0] wsBits;
        bit        ur;
        int        startCyc;
    } frame_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] leftIn = '0;
    logic [N-1:0] rightIn = '0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic         sck;
    logic         ws;
    logic         sd;
    logic         frameStart;
    logic         underrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    frame_t frQ[$];

    pcm_to_i2s #(
        .NUMBER_OF_BITS(N),
        .SLOT_BITS(SLOT),
        .CLK_DIV(DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .left_in(leftIn),
        .right_in(rightIn),
        .in_valid(inValid),
        .in_ready(inReady),
        .sck(sck),
        .ws(ws),
        .sd(sd),
        .frame_start(frameStart),
        .underrun(underrun)
    );

    // System clock
    always #5 clk = ~clk;

    // Cycle counter used to time frame starts
    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor: samples on the falling clk edge, records one bit per rising sck
    bit        active = 1'b0;
    bit        sckPrev = 1'b0;
    int        bitCnt = 0;
    frame_t    cur;
    always @(negedge clk) begin
        if (reset) begin
            active  = 1'b0;
            sckPrev = 1'b0;
        end else begin
            if (frameStart) begin
                active       = 1'b1;
                bitCnt       = 0;
                cur.sdBits   = '0;
                cur.wsBits   = '0;
                cur.ur       = underrun;
                cur.startCyc = cyc;
            end
            if (active && sck && !sckPrev) begin
                cur.sdBits[bitCnt] = sd;
                cur.wsBits[bitCnt] = ws;
                bitCnt++;
                if (bitCnt == 32) begin
                    frQ.push_back(cur);
                    active = 1'b0;
                end
            end
            sckPrev = sck;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] l, input logic [7:0] r);
        inValid = v;
        leftIn  = l;
        rightIn = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the next captured frame
    task automatic getFrame(input string name, output frame_t f, output bit ok);
        for (int i = 0; i < 400 && frQ.size() == 0; i++) tick();
        if (frQ.size() == 0) begin
            ok = 1'b0;
            total++;
            bad++;
            $display("[TB] FAIL %s: no frame captured within 400 cycles", name);
        end else begin
            ok = 1'b1;
            f  = frQ.pop_front();
        end
    endtask

    task automatic checkFrame(input string name, input logic [31:0] expSd, input logic expUr,
                              output frame_t f);
        bit ok;
        getFrame(name, f, ok);
        if (ok) begin
            checkOutput({name, " sd"}, f.sdBits, expSd);
            checkOutput({name, " ws"}, f.wsBits, WS_PATTERN);
            checkOutput({name, " underrun"}, {31'd0, f.ur}, {31'd0, expUr});
        end
    endtask

    task automatic waitFrameStart(input string name);
        int i;
        for (i = 0; i < 300 && !frameStart; i++) tick();
        checkOutput({name, " frame_start seen"}, {31'd0, frameStart}, 32'd1);
    endtask

    // Releases reset with A5/3C offered; the pair is accepted on the second edge
    task automatic releaseAndLoad(input string name, output int relCyc);
        reset  = 1'b0;
        relCyc = cyc;
        tick();
        checkOutput({name, " in_ready after release"}, {31'd0, inReady}, 32'd1);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput({name, " in_ready after accept"}, {31'd0, inReady}, 32'd0);
    endtask

    vec_t   tbl[4];
    frame_t f0;
    frame_t f1;
    frame_t fx;
    int     rel;
    int     idx;
    int     viol;
    bit     waiting;
    bit     acc;

    initial begin
        tbl[0] = '{l: 8'h01, r: 8'h81, expSd: 32'h0102_0100, expUr: 1'b0};
        tbl[1] = '{l: 8'h02, r: 8'h82, expSd: 32'h0082_0080, expUr: 1'b0};
        tbl[2] = '{l: 8'h03, r: 8'h83, expSd: 32'h0182_0180, expUr: 1'b0};
        tbl[3] = '{l: 8'h04, r: 8'h84, expSd: 32'h0042_0040, expUr: 1'b0};

        // Reset held with a pair offered: everything stays zero
        applyStimulus(1'b1, 8'hA5, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("reset outputs cycle %0d", i),
                        {26'd0, sck, ws, sd, inReady, frameStart, underrun}, 32'd0);
        end
        releaseAndLoad("first", rel);

        // Single frame carrying A5/3C
        checkFrame("frame A5/3C", 32'h0078_014A, 1'b0, f0);
        checkOutput("first frame_start latency", f0.startCyc - rel, 2 * DIV);

        // Two underrun frames
        checkFrame("underrun frame 1", 32'h0, 1'b1, f1);
        checkOutput("frame period", f1.startCyc - f0.startCyc, FRAME);
        checkFrame("underrun frame 2", 32'h0, 1'b1, fx);

        // Coincident accept and load
        waitFrameStart("coincident");
        for (int i = 0; i < FRAME - 1; i++) tick();
        applyStimulus(1'b1, 8'h5A, 8'hC3);
        tick();
        checkOutput("coincident frame_start", {31'd0, frameStart}, 32'd1);
        checkOutput("coincident underrun", {31'd0, underrun}, 32'd1);
        checkOutput("coincident accepted", {31'd0, inReady}, 32'd0);

        // Streaming table: one pair offered continuously after each accept
        idx     = 0;
        viol    = 0;
        waiting = 1'b0;
        applyStimulus(1'b1, tbl[0].l, tbl[0].r);
        for (int c = 0; c < 1500 && (idx < 4 || waiting); c++) begin
            acc = inValid && inReady;
            tick();
            if (acc) begin
                idx++;
                waiting = 1'b1;
                if (idx < 4) applyStimulus(1'b1, tbl[idx].l, tbl[idx].r);
                else applyStimulus(1'b0, 8'h00, 8'h00);
            end
            if (waiting) begin
                if (inReady) viol++;
                if (frameStart) waiting = 1'b0;
            end
        end
        checkOutput("stream accept count", idx, 4);
        checkOutput("stream in_ready low until frame_start", viol, 0);

        checkFrame("silent frame before coincident", 32'h0, 1'b1, fx);
        checkFrame("coincident silent frame", 32'h0, 1'b1, fx);
        checkFrame("coincident pair frame", 32'h0186_00B4, 1'b0, fx);
        for (int i = 0; i < 4; i++) begin
            checkFrame($sformatf("stream vec %0d", i), tbl[i].expSd, tbl[i].expUr, fx);
        end

        // Reset at p=5 with 11/22 waiting in the holding register
        waitFrameStart("midreset");
        applyStimulus(1'b1, 8'h11, 8'h22);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput("midreset hold filled", {31'd0, inReady}, 32'd0);
        for (int i = 0; i < 5 * 2 * DIV - 1; i++) tick();
        reset = 1'b1;
        applyStimulus(1'b1, 8'hA5, 8'h3C);
        tick();
        frQ.delete();
        checkOutput("midreset outputs",
                    {26'd0, sck, ws, sd, inReady, frameStart, underrun}, 32'd0);
        tick();
        tick();
        releaseAndLoad("after midreset", rel);
        checkFrame("after midreset A5/3C", 32'h0078_014A, 1'b0, f0);
        checkOutput("after midreset latency", f0.startCyc - rel, 2 * DIV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
